mips150_muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the MIPS150 core. It executes MULT/MULTU/DIV/DIVU over WIDTH+2 cycles and owns the HI/LO architectural registers. It services MFHI/MFLO/MTHI/MTLO and raises a stall request to the pipeline whenever an instruction touches HI/LO while an operation is in flight. It sits beside the ALU in the execute stage and is driven by the decoded funct field.

---
 rtl/mips150_muldiv_ctrl_pkg.sv | 14 +
 rtl/mips150_muldiv_step.sv | 33 +++
 rtl/mips150_muldiv_ctrl.sv | 152 +++++++++++++++
 tb/tb_mips150_muldiv_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips150_muldiv_ctrl_pkg.sv
// Shared funct-field encodings for the MIPS150 multiply/divide unit.
// Kept alongside the other RTYPE funct decodes used by the execute stage.
package mips150_muldiv_ctrl_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/mips150_muldiv_step.sv
// One iteration of the sequencer: a shift-add multiply step (LSB first)
// or a restoring shift-subtract divide step on a {hi,lo} accumulator.
module mips150_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 op_is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, hi the partial sum.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: partial remainder gets the next dividend bit shifted in.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, operand};
        if (op_is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips150_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MF/MT service
// and a stall request whenever HI/LO are touched while an op is in flight.
module mips150_muldiv_ctrl
    import mips150_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic             is_rtype,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]     operand_reg, operand_next;
    logic [WIDTH-1:0]     rs_raw_reg, rs_raw_next;
    logic [WIDTH-1:0]     hi_reg, hi_next;
    logic [WIDTH-1:0]     lo_reg, lo_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 is_div_reg, is_div_next;
    logic                 neg_q_reg, neg_q_next;
    logic                 neg_r_reg, neg_r_next;
    logic                 div0_reg, div0_next;
    logic                 done_reg;

    logic                 accept, start, mf, mt;
    logic                 op_signed, op_div;
    logic [WIDTH-1:0]     rs_abs, rt_abs;
    logic [2*WIDTH-1:0]   step_out;
    logic [2*WIDTH-1:0]   prod_fix;

    assign accept = valid & is_rtype;
    assign start  = accept & ((funct == FUNCT_MULT) | (funct == FUNCT_MULTU) |
                              (funct == FUNCT_DIV)  | (funct == FUNCT_DIVU));
    assign mf     = accept & ((funct == FUNCT_MFHI) | (funct == FUNCT_MFLO));
    assign mt     = accept & ((funct == FUNCT_MTHI) | (funct == FUNCT_MTLO));

    assign busy   = (state_reg != IDLE);
    assign stall  = busy & (start | mf | mt);
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign done   = done_reg;

    // Bit 1 separates divides from multiplies, bit 0 marks the unsigned forms.
    assign op_div    = funct[1];
    assign op_signed = ~funct[0];
    assign rs_abs    = (op_signed & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_abs    = (op_signed & rt_val[WIDTH-1]) ? -rt_val : rt_val;
    assign prod_fix  = neg_q_reg ? -acc_reg : acc_reg;

    mips150_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_is_div (is_div_reg),
        .acc       (acc_reg),
        .operand   (operand_reg),
        .acc_next  (step_out)
    );

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        operand_next = operand_reg;
        rs_raw_next  = rs_raw_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        cnt_next     = cnt_reg;
        is_div_next  = is_div_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        div0_next    = div0_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    is_div_next  = op_div;
                    operand_next = op_div ? rt_abs : rs_abs;
                    acc_next     = {{WIDTH{1'b0}}, (op_div ? rs_abs : rt_abs)};
                    neg_q_next   = op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    neg_r_next   = op_signed & rs_val[WIDTH-1];
                    div0_next    = op_div & (rt_val == '0);
                    rs_raw_next  = rs_val;
                    cnt_next     = '0;
                    state_next   = RUN;
                end else if (mt) begin
                    if (funct == FUNCT_MTHI) hi_next = rs_val;
                    else                     lo_next = rs_val;
                end
            end
            RUN: begin
                acc_next = step_out;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) state_next = FIXUP;
            end
            FIXUP: begin
                if (!is_div_reg) begin
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next = prod_fix[WIDTH-1:0];
                end else if (div0_reg) begin
                    hi_next = rs_raw_reg;
                    lo_next = '1;
                end else begin
                    lo_next = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                    hi_next = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            operand_reg <= '0;
            rs_raw_reg  <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            div0_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            operand_reg <= operand_next;
            rs_raw_reg  <= rs_raw_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            cnt_reg     <= cnt_next;
            is_div_reg  <= is_div_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            div0_reg    <= div0_next;
            done_reg    <= (state_reg == FIXUP);
        end
    end

endmodule

// File: tb/tb_mips150_muldiv_ctrl.sv
// Scoreboard bench for mips150_muldiv_ctrl: directed ops push expected
// {hi,lo}; a monitor pops and compares on every done pulse.
module tb_mips150_muldiv_ctrl;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [5:0]    funct;
    logic          is_rtype;
    logic [W-1:0]  rs_val, rt_val;
    logic [W-1:0]  hi, lo;
    logic          busy, done, stall;

    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] mon_exp;
    int n_checks   = 0;
    int n_fail     = 0;
    int done_count = 0;
    int busy_cycles;
    int dc_snap;

    always #5 clk = ~clk;

    mips150_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .funct    (funct),
        .is_rtype (is_rtype),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_exp = sb_q.pop_front();
                check("result_hi", hi, mon_exp[2*W-1:W]);
                check("result_lo", lo, mon_exp[W-1:0]);
                $display("result hi=0x%08h lo=0x%08h (exp 0x%08h 0x%08h)",
                         hi, lo, mon_exp[2*W-1:W], mon_exp[W-1:0]);
            end
        end
    end

    // Issue one op, scramble operands afterwards, and wait for its done pulse.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        sb_q.push_back({exp_hi, exp_lo});
        @(negedge clk);
        valid = 1'b1; is_rtype = 1'b1; funct = f; rs_val = a; rt_val = b;
        #1 check("stall_idle_start", {31'b0, stall}, 32'd0);
        $display("issue funct=0x%02h rs=0x%08h rt=0x%08h", f, a, b);
        @(negedge clk);
        valid = 1'b0; rs_val = $urandom; rt_val = $urandom;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("busy_cycles", busy_cycles, W + 1);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; funct = '0; is_rtype = 1'b0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        dc_snap = done_count;
        run_op(F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        repeat (3) @(negedge clk);
        check("done_once", done_count - dc_snap, 32'd1);

        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op(F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op(F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op(F_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);

        // MFLO right behind MULTU 6*7 must stall until the result lands.
        sb_q.push_back({32'd0, 32'd42});
        @(negedge clk);
        valid = 1'b1; is_rtype = 1'b1; funct = F_MULTU; rs_val = 32'd6; rt_val = 32'd7;
        @(negedge clk);
        funct = F_MFLO; rs_val = $urandom; rt_val = $urandom;
        #1;
        for (int i = 0; i < 100 && busy; i++) begin
            check("mflo_stall_busy", {31'b0, stall}, 32'd1);
            @(negedge clk); #1;
        end
        check("mflo_unstalled", {31'b0, stall}, 32'd0);
        check("mflo_value", lo, 32'd42);
        $display("mflo after multu 6*7 lo=0x%08h", lo);
        @(negedge clk);
        valid = 1'b0;

        // MTHI behind an op is held, then overwrites the op's hi.
        sb_q.push_back({32'd0, 32'd42});
        @(negedge clk);
        valid = 1'b1; funct = F_MULTU; rs_val = 32'd6; rt_val = 32'd7;
        @(negedge clk);
        funct = F_MTHI; rs_val = 32'h1234; rt_val = $urandom;
        #1;
        for (int i = 0; i < 100 && busy; i++) begin
            check("mthi_stall_busy", {31'b0, stall}, 32'd1);
            @(negedge clk); #1;
        end
        check("mthi_unstalled", {31'b0, stall}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo_kept", lo, 32'd42);
        $display("mthi after multu hi=0x%08h lo=0x%08h", hi, lo);

        // MTLO while idle.
        @(negedge clk);
        valid = 1'b1; funct = F_MTLO; rs_val = 32'hABCD;
        #1 check("mtlo_nostall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        check("mtlo_lo", lo, 32'hABCD);
        check("mtlo_hi_kept", hi, 32'h1234);
        $display("mtlo idle lo=0x%08h", lo);

        // Reset during RUN of DIV 100/3 abandons the op.
        dc_snap = done_count;
        @(negedge clk);
        valid = 1'b1; funct = F_DIV; rs_val = 32'd100; rt_val = 32'd3;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_count - dc_snap, 32'd0);
        $display("reset abort hi=0x%08h lo=0x%08h", hi, lo);

        run_op(F_DIVU, 32'd100, 32'd3, 32'd1, 32'd33);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
